bus_owner_switcher: RTL

//  Parametrised arbiter that shares one SRAM bus (ram1 address, data and OE/WE/EN) among NUM_MASTERS machines (e.g. RAM tester, UART controller).

---
 rtl/bus_owner_switcher.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_owner_switcher.sv
// rtl/bus_owner_switcher.sv - shares one SRAM bus among several masters, one word per grant
// Ownership moves only in IDLE; every grant runs SETUP, STROBE, HOLD and a TURN cycle.
module bus_owner_switcher #(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_W       = 1,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          rr_en,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [SEL_W-1:0]              owner,
  output logic                          busy,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_dout,
  output logic                          ram_dout_en,
  input  logic [DATA_W-1:0]             ram_din,
  output logic                          ram_en_n,
  output logic                          ram_oe_n,
  output logic                          ram_we_n
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_TURN   = 3'd4;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             cur_we;
  logic [SEL_W-1:0] cand;
  logic             cand_hit;
  logic             cand_we;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_wdata;

  // Round-robin scans owner+1 upward with wrap, so the current owner is looked at last.
  always_comb begin
    cand     = owner;
    cand_hit = 1'b0;
    if (rr_en) begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        if (!cand_hit && |(m_req & (NUM_MASTERS'(1) << ((int'(owner) + k) % NUM_MASTERS)))) begin
          cand     = SEL_W'((int'(owner) + k) % NUM_MASTERS);
          cand_hit = 1'b1;
        end
      end
    end else begin
      if (int'(sel) < NUM_MASTERS) cand = sel;
      cand_hit = |(m_req & (NUM_MASTERS'(1) << cand));
    end
    cand_we    = |(m_we & (NUM_MASTERS'(1) << cand));
    cand_addr  = ADDR_W'(m_addr >> (int'(cand) * ADDR_W));
    cand_wdata = DATA_W'(m_wdata >> (int'(cand) * DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      cur_we      <= 1'b0;
      owner       <= '0;
      busy        <= 1'b0;
      m_ack       <= '0;
      m_rdata     <= '0;
      ram_addr    <= '0;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
      ram_en_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
    end else begin
      m_ack <= '0;
      case (state)
        S_IDLE: begin
          owner <= cand;
          if (cand_hit) begin
            state    <= S_SETUP;
            busy     <= 1'b1;
            cur_we   <= cand_we;
            ram_addr <= cand_addr;
            ram_en_n <= 1'b0;
            if (cand_we) begin
              ram_dout    <= cand_wdata;
              ram_dout_en <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          state    <= S_STROBE;
          wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
          if (cur_we) ram_we_n <= 1'b0;
          else        ram_oe_n <= 1'b0;
        end
        S_STROBE: begin
          if (wait_cnt == '0) begin
            state    <= S_HOLD;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            m_ack    <= NUM_MASTERS'(1) << owner;
            if (!cur_we) m_rdata <= ram_din;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          state       <= S_TURN;
          ram_en_n    <= 1'b1;
          ram_dout_en <= 1'b0;
        end
        S_TURN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          ram_en_n    <= 1'b1;
          ram_oe_n    <= 1'b1;
          ram_we_n    <= 1'b1;
          ram_dout_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
